// File: rtl/demux_pack_param_if.sv
// demux_pack_param_if: serial lane-tagged input and packed wide output of the packing demux
interface demux_pack_param_if #(
  parameter int BITS  = 2,
  parameter int SIZE  = 4,
  parameter int WIDTH = 1
);
  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0]      in_data;
  logic [BITS-1:0]       in_select;
  logic                  in_flush;
  logic                  out_valid;
  logic                  out_ready;
  logic [SIZE*WIDTH-1:0] out_data;
  logic [SIZE-1:0]       out_mask;
  logic                  dup_err;
  logic                  sel_err;
  modport master (
    output in_valid, in_data, in_select, in_flush, out_ready,
    input  in_ready, out_valid, out_data, out_mask, dup_err, sel_err
  );
  modport slave (
    input  in_valid, in_data, in_select, in_flush, out_ready,
    output in_ready, out_valid, out_data, out_mask, dup_err, sel_err
  );
endinterface

// File: rtl/demux_pack_slot.sv
// demux_pack_slot: one packing-buffer slot with write enable and synchronous clear
module demux_pack_slot #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= '0;
    else if (clr) q <= '0;
    else if (we) q <= d;
endmodule

// File: rtl/demux_pack_param.sv
// demux_pack_param: gathers lane-tagged words into a SIZE-slot buffer and emits
// the packed vector with a fill mask on a valid/ready port.
module demux_pack_param #(
  parameter int BITS  = 2,
  parameter int SIZE  = 4,
  parameter int WIDTH = 1
) (
  input logic clk,
  input logic rst,
  demux_pack_param_if.slave bus
);
  localparam logic FILL = 1'b0;
  localparam logic HOLD = 1'b1;
  localparam logic [SIZE-1:0] FULL = {SIZE{1'b1}};
  logic                  state;
  logic [SIZE-1:0]       mask, hit, mask_post;
  logic [SIZE*WIDTH-1:0] data;
  logic                  accept, sel_ok, wr, clr;
  // widened compare keeps SIZE == 2**BITS from truncating to zero
  assign sel_ok    = {1'b0, bus.in_select} < (BITS+1)'(SIZE);
  assign accept    = bus.in_valid & (state == FILL);
  assign wr        = accept & sel_ok;
  assign clr       = (state == HOLD) & bus.out_ready;
  assign mask_post = mask | hit;
  for (genvar i = 0; i < SIZE; i++) begin : g_slot
    assign hit[i] = wr && (bus.in_select == BITS'(i));
    demux_pack_slot #(.WIDTH(WIDTH)) u_slot (
      .clk(clk), .rst(rst), .we(hit[i]), .clr(clr),
      .d(bus.in_data), .q(data[i*WIDTH +: WIDTH])
    );
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state        <= FILL;
      mask         <= '0;
      bus.dup_err  <= 1'b0;
      bus.sel_err  <= 1'b0;
    end else begin
      bus.dup_err <= wr & |(hit & mask);
      bus.sel_err <= accept & ~sel_ok;
      if (accept) begin
        mask <= mask_post;
        if (mask_post == FULL || (bus.in_flush && |mask_post)) state <= HOLD;
      end else if (clr) begin
        mask  <= '0;
        state <= FILL;
      end
    end
  assign bus.in_ready  = (state == FILL) & ~rst;
  assign bus.out_valid = (state == HOLD);
  assign bus.out_data  = data;
  assign bus.out_mask  = mask;
endmodule

// File: tb/tb_demux_pack_param.sv
// tb_demux_pack_param: directed checks of packing, flush, errors, backpressure and async reset
module tb_demux_pack_param;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  demux_pack_param_if #(.BITS(2), .SIZE(4), .WIDTH(8)) b4 ();
  demux_pack_param_if #(.BITS(2), .SIZE(3), .WIDTH(8)) b3 ();
  demux_pack_param #(.BITS(2), .SIZE(4), .WIDTH(8)) dut4 (.clk(clk), .rst(rst), .bus(b4));
  demux_pack_param #(.BITS(2), .SIZE(3), .WIDTH(8)) dut3 (.clk(clk), .rst(rst), .bus(b3));
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic put(input logic [7:0] d, input logic [1:0] s, input logic f);
    b4.in_valid = 1'b1; b4.in_data = d; b4.in_select = s; b4.in_flush = f;
    @(negedge clk);
    b4.in_valid = 1'b0; b4.in_flush = 1'b0;
  endtask
  task automatic release_pkt();
    b4.out_ready = 1'b1;
    @(negedge clk);
    b4.out_ready = 1'b0;
  endtask
  initial begin
    b4.in_valid = 0; b4.in_data = 0; b4.in_select = 0; b4.in_flush = 0; b4.out_ready = 0;
    b3.in_valid = 0; b3.in_data = 0; b3.in_select = 0; b3.in_flush = 0; b3.out_ready = 0;
    #2;
    chk("rst_in_ready", b4.in_ready, 0);
    chk("rst_out_valid", b4.out_valid, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", b4.in_ready, 1);
    chk("post_rst_mask", b4.out_mask, 0);
    chk("post_rst_data", b4.out_data, 0);
    chk("post_rst_errs", {b4.dup_err, b4.sel_err}, 0);
    // full fill
    put(8'hA1, 0, 0); put(8'hB2, 1, 0); put(8'hC3, 2, 0);
    chk("fill_not_yet_valid", b4.out_valid, 0);
    put(8'hD4, 3, 0);
    chk("fill_valid", b4.out_valid, 1);
    chk("fill_data", b4.out_data, 32'hD4C3B2A1);
    chk("fill_mask", b4.out_mask, 4'b1111);
    for (int i = 0; i < 5; i++) begin
      chk("fill_in_ready_low", b4.in_ready, 0);
      if (i < 4) @(negedge clk);
    end
    release_pkt();
    chk("rel_out_valid", b4.out_valid, 0);
    chk("rel_in_ready", b4.in_ready, 1);
    chk("rel_cleared", {b4.out_mask, b4.out_data}, 0);
    // out-of-order plus flush
    put(8'h55, 2, 0); put(8'h66, 0, 1);
    chk("flush_valid", b4.out_valid, 1);
    chk("flush_data", b4.out_data, 32'h00550066);
    chk("flush_mask", b4.out_mask, 4'b0101);
    release_pkt();
    // duplicate write
    put(8'h11, 1, 0);
    chk("dup_first_none", b4.dup_err, 0);
    put(8'h22, 1, 0);
    chk("dup_pulse", b4.dup_err, 1);
    chk("dup_no_sel", b4.sel_err, 0);
    put(8'h33, 0, 1);
    chk("dup_one_cycle", b4.dup_err, 0);
    chk("dup_data", b4.out_data, 32'h00002233);
    chk("dup_mask", b4.out_mask, 4'b0011);
    release_pkt();
    // bad select with flush on the 3-slot instance
    b3.in_valid = 1; b3.in_data = 8'h77; b3.in_select = 3; b3.in_flush = 1;
    @(negedge clk);
    b3.in_valid = 0; b3.in_flush = 0;
    chk("sel_pulse", b3.sel_err, 1);
    chk("sel_no_dup", b3.dup_err, 0);
    chk("sel_no_valid", b3.out_valid, 0);
    chk("sel_in_ready", b3.in_ready, 1);
    chk("sel_mask", b3.out_mask, 0);
    @(negedge clk);
    chk("sel_one_cycle", b3.sel_err, 0);
    // backpressure in HOLD
    put(8'h01, 0, 0); put(8'h02, 1, 0); put(8'h03, 2, 0); put(8'h04, 3, 0);
    b4.in_valid = 1; b4.in_data = 8'hFF; b4.in_select = 0; b4.in_flush = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_data", b4.out_data, 32'h04030201);
      chk("bp_errs", {b4.dup_err, b4.sel_err}, 0);
      chk("bp_valid", b4.out_valid, 1);
    end
    b4.in_valid = 0; b4.in_flush = 0;
    release_pkt();
    chk("bp_not_captured", {b4.out_mask, b4.out_data}, 0);
    // async reset mid-packet
    put(8'hAA, 0, 0); put(8'hBB, 1, 0);
    chk("pre_rst_mask", b4.out_mask, 4'b0011);
    #2 rst = 1'b1;
    #1;
    chk("arst_data", b4.out_data, 0);
    chk("arst_mask", b4.out_mask, 0);
    chk("arst_ctrl", {b4.in_ready, b4.out_valid, b4.dup_err, b4.sel_err}, 0);
    @(negedge clk);
    rst = 1'b0;
    put(8'h10, 0, 0); put(8'h20, 1, 0); put(8'h30, 2, 0); put(8'h40, 3, 0);
    chk("arst_refill_data", b4.out_data, 32'h40302010);
    chk("arst_refill_mask", b4.out_mask, 4'b1111);
    release_pkt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/demux_pack_param.md
Name: demux_pack_param

Overview:
- Inverse of a parameterized lane-select mux. Accepts one WIDTH-bit word per cycle, tagged with a lane index.
- Writes each word into the addressed slot of a SIZE-slot packing buffer.
- Presents the assembled SIZE*WIDTH vector, with a per-slot fill mask, on a valid/ready output port.
- Used wherever per-lane results arrive serially and must be handed on as one wide bus, e.g. gathering lane data before a wide register-file write.

Parameters:
- BITS, 2: width of the lane-select field.
- SIZE, 4: number of slots; must satisfy SIZE <= 2**BITS.
- WIDTH, 1: bits per slot.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_data/in_select valid this cycle.
- in_ready  output  1  block can accept a word.
- in_data  input  WIDTH  word to store.
- in_select  input  BITS  destination slot index.
- in_flush  input  1  qualified by in_valid: close the current packet after this cycle's write.
- out_valid  output  1  packed vector available.
- out_ready  input  1  consumer takes the packed vector.
- out_data  output  SIZE*WIDTH  slot i at bits [(i+1)*WIDTH-1 -: WIDTH].
- out_mask  output  SIZE  bit i = slot i written in this packet.
- dup_err  output  1  one-cycle pulse: previous accepted write overwrote an already-filled slot.
- sel_err  output  1  one-cycle pulse: previous accepted write had in_select >= SIZE.

Behaviour:
- Reset (async, rst=1): all slots 0, mask 0, state FILL, out_valid 0, dup_err 0, sel_err 0. in_ready is 0 while rst is high and 1 on the first cycle after release.
- States: FILL and HOLD, as localparam encodings.
- in_ready = (state == FILL). It is combinational from state only; there is no same-cycle bypass from out_ready.
- Accept = in_valid & in_ready.
- On accept with in_select < SIZE:
  - slot[in_select] <= in_data; mask[in_select] <= 1.
  - If that mask bit was already 1: overwrite anyway, and dup_err = 1 in the next cycle.
- On accept with in_select >= SIZE:
  - Word dropped; mask unchanged; sel_err = 1 in the next cycle.
- FILL -> HOLD at the edge of an accept when either:
  - the post-write mask is all ones, or
  - in_flush = 1 and the post-write mask is nonzero.
- out_valid = (state == HOLD). Latency: the last word is accepted at edge N and out_valid is high from cycle N+1.
- Flush with an empty post-write mask (including a flush that comes with a dropped word): ignored, stay in FILL. No empty packets are ever emitted.
- Flush when the mask is already all ones: identical to a normal fill.
- in_flush without in_valid: ignored.
- In HOLD:
  - out_data and out_mask are stable.
  - in_valid is ignored (not accepted, no error pulses).
  - When out_ready = 1: at that edge, clear slots and mask, go to FILL. in_ready = 1 on the next cycle.
- Unwritten slots read as 0 in out_data.
- out_ready while in FILL: no effect.
- dup_err and sel_err are single-cycle, registered, never both set for one write. They are 0 otherwise.
- Reset mid-packet or in HOLD: partial data is discarded, outputs return to reset values immediately (async).
- No arithmetic beyond the index compare. The in_select >= SIZE compare is done at BITS+1 width to avoid truncation when SIZE == 2**BITS.

Decomposition:
- No shared package is needed. FILL/HOLD encodings and the all-ones mask constant are localparams.
- One natural sub-module: demux_pack_slot (WIDTH-bit register with write-enable and synchronous clear), instanced SIZE times via generate.
- Mask, state and error logic stay in the top level.

Test Plan:
- Full fill (SIZE=4, WIDTH=8): writes A1@0, B2@1, C3@2, D4@3 on consecutive cycles, out_ready=0. Expect:
  - out_valid rises the cycle after D4.
  - out_data=0xD4C3B2A1, out_mask=4'b1111.
  - in_ready=0 held for 5 cycles.
  - After an out_ready pulse: out_valid=0 and in_ready=1 next cycle.
- Out-of-order plus flush: writes 55@2, then 66@0 with in_flush. Expect out_data=0x00550066, out_mask=4'b0101.
- Duplicate: writes 11@1 then 22@1. Expect dup_err=1 for exactly one cycle after the second write, and slot1=0x22 at output.
- Bad select (SIZE=3, BITS=2): write 77@3 with in_flush, mask empty. Expect sel_err pulse, no state change, out_valid stays 0.
- Backpressure: in HOLD, drive in_valid=1 with new data for 3 cycles. Expect no change to out_data, no error pulses, and data not captured.
- Async reset: assert rst mid-packet (2 slots filled) between clock edges. Expect all outputs 0 immediately. After release, a full 4-word fill produces only the new data.
